// File: rtl/imem_ahb_slave_rv32_if.sv
// AHB-Lite fetch-port bundle between the RV32 core (master) and the instruction memory (slave).
interface imem_ahb_slave_rv32_if;
    logic        hsel_in;
    logic [31:0] haddr_in;
    logic [1:0]  htrans_in;
    logic [2:0]  hsize_in;
    logic        hwrite_in;
    logic        hready_in;
    logic [31:0] hrdata_out;
    logic        hreadyout_out;
    logic        hresp_out;

    modport slave (
        input  hsel_in, haddr_in, htrans_in, hsize_in, hwrite_in, hready_in,
        output hrdata_out, hreadyout_out, hresp_out
    );

    modport master (
        output hsel_in, haddr_in, htrans_in, hsize_in, hwrite_in, hready_in,
        input  hrdata_out, hreadyout_out, hresp_out
    );
endinterface

// File: rtl/imem_ahb_slave_rv32.sv
// Read-only AHB-Lite instruction memory with programmable wait states, two-cycle ERROR
// response for illegal fetches, and a side-band preload port.
module imem_ahb_slave_rv32 #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    imem_ahb_slave_rv32_if.slave         bus,
    input  logic                         load_en_in,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr_in,
    input  logic [31:0]                  load_data_in
);
    localparam int unsigned AW       = $clog2(MEM_DEPTH);
    localparam logic [2:0]  CNT_INIT = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] buf_q;
    logic [31:0] hrdata_q;
    logic        hreadyout_q;
    logic        hresp_q;

    logic [31:0] mem_q [MEM_DEPTH];

    logic [31:0]   offset;
    logic          valid;
    logic          in_range;
    logic          err;
    logic [AW-1:0] fetch_idx;
    logic [31:0]   rd_word;

    always_comb begin
        offset    = bus.haddr_in - BASE_ADDR;
        valid     = bus.hsel_in & bus.hready_in & bus.htrans_in[1];
        // Whole offset must fit the array: out-of-range addresses error instead of aliasing.
        in_range  = ((offset >> (AW + 2)) == '0);
        err       = bus.hwrite_in | (bus.hsize_in != 3'b010) |
                    (bus.haddr_in[1:0] != 2'b00) | ~in_range;
        fetch_idx = offset[AW+1:2];
        rd_word   = mem_q[fetch_idx];
    end

    always_ff @(posedge clk_in) begin
        if (load_en_in) begin
            mem_q[load_addr_in] <= load_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            buf_q       <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            case (state_q)
                // DATA accepts a pipelined address phase exactly like IDLE does.
                S_IDLE, S_DATA: begin
                    if (valid && !err) begin
                        hresp_q <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state_q     <= S_DATA;
                            hrdata_q    <= rd_word;
                            hreadyout_q <= 1'b1;
                        end else begin
                            state_q     <= S_WAIT;
                            cnt_q       <= CNT_INIT;
                            buf_q       <= rd_word;
                            hreadyout_q <= 1'b0;
                        end
                    end else if (valid) begin
                        state_q     <= S_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                // The word was captured at acceptance, so a later preload cannot change it.
                S_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        state_q     <= S_DATA;
                        hrdata_q    <= buf_q;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hrdata_q    <= '0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                S_ERR2: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hrdata_out    = hrdata_q;
    assign bus.hreadyout_out = hreadyout_q;
    assign bus.hresp_out     = hresp_q;
endmodule
